// File: rtl/lightcube_pkg.sv
// Shared frame geometry, default header byte and assembler state encoding.
package lightcube_pkg;
    localparam int FRAME_BYTES = 64;
    localparam int FRAME_BITS  = 512;

    localparam logic [7:0] DEFAULT_HEADER = 8'hF2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } frame_state_e;
endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out bundle between the UART receiver, the assembler and the frame buffer.
interface uart_frame_assembler_if;
    import lightcube_pkg::*;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [FRAME_BITS-1:0] frame_cube_uart_flat;
    logic                  frame_valid_uart;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output rx_data, rx_valid,
        input  frame_cube_uart_flat, frame_valid_uart, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output frame_cube_uart_flat, frame_valid_uart, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_assembler_idle_timer.sv
// Clearable, enabled idle counter; term is high while the count sits at TIMEOUT_CYCLES-1.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] TERM_CNT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign term = (count == TERM_CNT);

    // Saturates at the terminal value so term stays asserted until cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !term)
            count <= count + W'(1);
    end
endmodule

// File: rtl/uart_frame_assembler.sv
// Collects header + 64 data bytes into a shadow frame and commits it atomically.
// Build option FRAME_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module uart_frame_assembler
    import lightcube_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_frame_assembler_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DATA = DATA;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = CSUM;
`endif

    logic [1:0]                  state;
    logic [5:0]                  cnt;
    logic [FRAME_BYTES-1:0][7:0] shadow, shadow_nxt;
    logic [FRAME_BITS-1:0]       frame_q;
    logic                        valid_q, err_q;
    logic                        term, timeout, in_frame;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]                  sum;
`endif

    assign in_frame = (state != ST_IDLE);

    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.rx_valid || !in_frame),
        .en   (in_frame),
        .term (term)
    );

    // A byte on the terminal cycle wins over the timeout.
    assign timeout = term && !bus.rx_valid && in_frame;

    // Shadow with this cycle's byte merged in, so slot 63 can commit on the same edge.
    always_comb begin
        shadow_nxt = shadow;
        if (state == ST_DATA && bus.rx_valid)
            shadow_nxt[cnt] = bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shadow  <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            shadow  <= shadow_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid && bus.rx_data == HEADER) begin
                        state <= ST_DATA;
                        cnt   <= '0;
`ifdef FRAME_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid) begin
                        cnt <= cnt + 6'd1;
`ifdef FRAME_CHECKSUM_EN
                        sum <= sum + bus.rx_data;
                        if (cnt == 6'd63)
                            state <= ST_CSUM;
`else
                        if (cnt == 6'd63) begin
                            frame_q <= shadow_nxt;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
`endif
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CSUM: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == sum) begin
                            frame_q <= shadow;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.frame_cube_uart_flat = frame_q;
    assign bus.frame_valid_uart     = valid_q;
    assign bus.frame_err            = err_q;
    assign bus.busy                 = in_frame;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Table-driven frames plus hand-written timeout / reset sequences, scoreboard of committed frames.
module tb_uart_frame_assembler;
    import lightcube_pkg::*;

    localparam int TO = 16;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_frame_assembler_if bus ();

    uart_frame_assembler #(.HEADER(8'hF2), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int valid_pulses = 0;
    int err_pulses = 0;
    int exp_valid = 0;
    int exp_err = 0;
    logic [511:0] model_bus;
    logic [511:0] sb[$];

    typedef struct {
        string      nm;
        bit         junk;
        logic [7:0] base;
        logic [7:0] step;
        bit         hdr5;
        bit         bad;
    } vec_t;

    vec_t tbl[6];

    always @(negedge clk) begin
        if (bus.frame_valid_uart) valid_pulses <= valid_pulses + 1;
        if (bus.frame_err)        err_pulses   <= err_pulses + 1;
    end

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] sum8(input logic [511:0] f);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < 64; k++) s = s + f[8*k +: 8];
        return s;
    endfunction

    function automatic logic [511:0] build(input logic [7:0] base, input logic [7:0] step, input bit hdr5);
        logic [511:0] f;
        for (int k = 0; k < 64; k++) f[8*k +: 8] = base + 8'(k) * step;
        if (hdr5) f[47:40] = 8'hF2;
        return f;
    endfunction

    // Sends a full frame (optional idle gap after data byte 0) and checks the outcome at
    // the cycle right after the final byte's sampling edge.
    task automatic send_frame(input string nm, input logic [511:0] f, input logic [7:0] ck, input int gap);
        bit commit;
        send_byte(8'hF2);
        for (int k = 0; k < 64; k++) begin
            send_byte(f[8*k +: 8]);
            if (k == 0 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        commit = 1'b1;
        if (CSUM_EN) begin
            send_byte(ck);
            commit = (ck == sum8(f));
        end
        if (commit) begin
            sb.push_back(f);
            exp_valid++;
        end else begin
            exp_err++;
        end
        check({nm, " valid"}, 512'(bus.frame_valid_uart), 512'(commit));
        check({nm, " err"}, 512'(bus.frame_err), 512'(!commit));
        if (bus.frame_valid_uart && sb.size() > 0) model_bus = sb.pop_front();
        check({nm, " bus"}, bus.frame_cube_uart_flat, model_bus);
        check({nm, " busy"}, 512'(bus.busy), 512'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] f;
        logic [7:0]   ck;
        int           got;

        tbl[0] = '{"ramp",    1'b0, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[1] = '{"ones",    1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{"bad_ck",  1'b0, 8'h01, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{"good_ck", 1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{"hdr5",    1'b0, 8'hA5, 8'h07, 1'b1, 1'b0};
        tbl[5] = '{"mix",     1'b1, 8'h3C, 8'h13, 1'b0, 1'b0};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_bus    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset bus", bus.frame_cube_uart_flat, '0);
        check("reset busy", 512'(bus.busy), 512'(0));
        check("reset valid", 512'(bus.frame_valid_uart), 512'(0));
        check("reset err", 512'(bus.frame_err), 512'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Frames follow each other with no gap: each header lands in the cycle after a commit.
        for (int i = 0; i < 6; i++) begin
            f = build(tbl[i].base, tbl[i].step, tbl[i].hdr5);
            ck = sum8(f) + 8'(tbl[i].bad);
            if (tbl[i].junk) begin
                send_byte(8'h11);
                send_byte(8'h55);
            end
            send_frame(tbl[i].nm, f, ck, 0);
            if (i == 0) begin
                check("ramp slot0", 512'(bus.frame_cube_uart_flat[7:0]), 512'(8'h00));
                check("ramp slot63", 512'(bus.frame_cube_uart_flat[511:504]), 512'(8'h3F));
                if (CSUM_EN) check("ramp csum", 512'(ck), 512'(8'hE0));
            end
            if (i == 1) check("ones bus", bus.frame_cube_uart_flat, {512{1'b1}});
            if (i == 4) check("hdr5 slot5", 512'(bus.frame_cube_uart_flat[47:40]), 512'(8'hF2));
        end

        // Inter-byte timeout after 10 data bytes.
        send_byte(8'hF2);
        for (int k = 0; k < 10; k++) send_byte(8'(k + 8'h80));
        got = 0;
        for (int i = 1; i <= TO + 4; i++) begin
            @(posedge clk);
            #1;
            if (i == TO - 1) check("timeout busy before", 512'(bus.busy), 512'(1));
            if (bus.frame_err) begin
                got = i;
                break;
            end
        end
        exp_err++;
        check("timeout latency", 512'(got), 512'(TO));
        check("timeout busy", 512'(bus.busy), 512'(0));
        check("timeout bus", bus.frame_cube_uart_flat, model_bus);
        check("timeout valid", 512'(bus.frame_valid_uart), 512'(0));
        f = build(8'h10, 8'h03, 1'b0);
        send_frame("after_to", f, sum8(f), 0);

        // A byte arriving exactly on the timeout terminal cycle keeps the frame alive.
        f = build(8'h22, 8'h05, 1'b0);
        send_frame("byte_wins", f, sum8(f), TO - 1);

        // Reset in the middle of a frame.
        send_byte(8'hF2);
        for (int k = 0; k < 30; k++) send_byte(8'(k));
        rst = 1'b0;
        #1;
        check("midreset bus", bus.frame_cube_uart_flat, '0);
        check("midreset busy", 512'(bus.busy), 512'(0));
        model_bus = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        f = build(8'h77, 8'h0B, 1'b0);
        send_frame("after_rst", f, sum8(f), 0);

        repeat (3) @(posedge clk);
        #1;
        check("valid pulses", 512'(valid_pulses), 512'(exp_valid));
        check("err pulses", 512'(err_pulses), 512'(exp_err));
        check("scoreboard empty", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
